fetch_queue_unit: RTL

- Parametrised successor to the single-cycle PC/instruction-memory path of the 8-bit core.
- Owns the program counter and issues instruction-memory reads over a req/ack handshake.
- Buffers fetched instructions with their PCs in a DEPTH-entry prefetch queue.
- Supports redirect (beq/j/jal/jr target from the decode/execute side), which flushes the queue and discards any in-flight fetch.

---
 rtl/fetch_queue_unit.sv | 98 +++++++++
 1 files changed

// File: rtl/fetch_queue_unit.sv
// Instruction fetch front end: owns the PC, issues req/ack reads to instruction
// memory and buffers {instruction, pc} pairs in a DEPTH-entry prefetch queue.
module fetch_queue_unit #(
  parameter int          ADDR_W   = 8,
  parameter int          INST_W   = 8,
  parameter int          DEPTH    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_ack,
  input  logic [INST_W-1:0]        mem_rdata,
  output logic                     inst_valid,
  output logic [INST_W-1:0]        inst,
  output logic [ADDR_W-1:0]        inst_pc,
  input  logic                     inst_ready,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_target,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     dbgState
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {FETCH = 1'b0, STALL = 1'b1} stateE;

  stateE             state;
  logic [ADDR_W-1:0] fetchPc;
  logic [PTR_W-1:0]  headPtr;
  logic [PTR_W-1:0]  tailPtr;
  logic [INST_W-1:0] qInst [DEPTH];
  logic [ADDR_W-1:0] qPc   [DEPTH];

  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  countNext;
  logic              nextFetch;

  // Handshakes: a memory read completes when mem_req & mem_ack (rdata valid that
  // cycle); a queue entry is consumed when inst_valid & inst_ready. Redirect
  // overrides both, so nothing transfers in a redirect cycle.
  assign push = mem_req & mem_ack & ~redirect;
  assign pop  = inst_valid & inst_ready & ~redirect;

  always_comb begin
    countNext = count;
    if (redirect)
      countNext = '0;
    else
      countNext = count + CNT_W'(push) - CNT_W'(pop);
  end

  // Keep requesting unless this cycle's update leaves the queue full.
  assign nextFetch = redirect || (countNext != CNT_W'(DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      mem_req <= 1'b0;
      fetchPc <= ADDR_W'(RESET_PC);
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        qInst[i] <= '0;
        qPc[i]   <= '0;
      end
    end else begin
      count   <= countNext;
      state   <= nextFetch ? FETCH : STALL;
      mem_req <= nextFetch;
      if (redirect) begin
        headPtr <= '0;
        tailPtr <= '0;
        fetchPc <= redirect_target;
      end else begin
        if (push) begin
          qInst[tailPtr] <= mem_rdata;
          qPc[tailPtr]   <= fetchPc;
          tailPtr        <= tailPtr + 1'b1;
          fetchPc        <= fetchPc + 1'b1;
        end
        if (pop)
          headPtr <= headPtr + 1'b1;
      end
    end
  end

  assign mem_addr   = fetchPc;
  assign inst_valid = (count != '0);
  assign inst       = inst_valid ? qInst[headPtr] : '0;
  assign inst_pc    = inst_valid ? qPc[headPtr]   : '0;
  assign dbgState   = (state == STALL);

endmodule
